// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing single-outstanding imem word fetches and presenting instructions to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] tgt;
  assign tgt        = redirect_pc & ~32'h3;
  assign imem_req   = state_q == REQ;
  assign imem_addr  = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        pc_d    = redirect ? tgt : pc_q;
      end
      REQ: begin
        if (redirect) begin
          pc_d    = tgt;
          state_d = imem_gnt ? DROP : REQ;
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = tgt;
          state_d = imem_rvalid ? REQ : DROP;
        end else if (imem_rvalid) begin
          inst_d       = imem_rdata;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_q + 32'd4;
          state_d      = HOLD;
        end
      end
      DROP: begin
        pc_d    = redirect ? tgt : pc_q;
        state_d = imem_rvalid ? REQ : DROP;
      end
      HOLD: begin
        if (redirect || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = REQ;
        end
        pc_d = redirect ? tgt : pc_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0000_0013;
      inst_pc_q    <= 32'h0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus reset/wrap sequences for fetch_stage.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic        gnt, rv, rd, rdy;
    logic [31:0] rdata, rpc;
    logic        req, v;
    logic [31:0] addr, inst, ipc;
  } vec_t;
  logic        clk = 1'b0;
  logic [1:0]  rst_n, gnt, rv, rd, rdy, req, v;
  logic [31:0] rdata[2], rpc[2], addr[2], inst[2], ipc[2];
  int          n_chk = 0, n_fail = 0;
  vec_t        tbl[$];
  always #5 clk = ~clk;
  fetch_stage dut0 (
    .clk(clk), .rst_n(rst_n[0]), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_gnt(gnt[0]), .imem_rvalid(rv[0]), .imem_rdata(rdata[0]),
    .redirect(rd[0]), .redirect_pc(rpc[0]), .inst_valid(v[0]),
    .inst_ready(rdy[0]), .inst(inst[0]), .inst_pc(ipc[0])
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_gnt(gnt[1]), .imem_rvalid(rv[1]), .imem_rdata(rdata[1]),
    .redirect(rd[1]), .redirect_pc(rpc[1]), .inst_valid(v[1]),
    .inst_ready(rdy[1]), .inst(inst[1]), .inst_pc(ipc[1])
  );
  function automatic vec_t mk(logic g, logic r, logic [31:0] d, logic x, logic [31:0] p, logic y,
                              logic eq, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    vec_t t;
    t.gnt = g; t.rv = r; t.rdata = d; t.rd = x; t.rpc = p; t.rdy = y;
    t.req = eq; t.addr = ea; t.v = ev; t.inst = ei; t.ipc = ep;
    return t;
  endfunction
  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic chk_out(int d, int idx, logic eq, logic [31:0] ea, logic ev, logic [31:0] ei, logic [31:0] ep);
    chk("imem_req", idx, {31'b0, req[d]}, {31'b0, eq});
    chk("imem_addr", idx, addr[d], ea);
    chk("inst_valid", idx, {31'b0, v[d]}, {31'b0, ev});
    chk("inst", idx, inst[d], ei);
    chk("inst_pc", idx, ipc[d], ep);
  endtask
  task automatic step(int d, int idx, vec_t t);
    @(negedge clk);
    gnt[d] = t.gnt; rv[d] = t.rv; rdata[d] = t.rdata; rd[d] = t.rd; rpc[d] = t.rpc; rdy[d] = t.rdy;
    @(posedge clk);
    #1;
    chk_out(d, idx, t.req, t.addr, t.v, t.inst, t.ipc);
  endtask
  initial begin
    rst_n = 2'b00; gnt = '0; rv = '0; rd = '0; rdy = '0;
    for (int i = 0; i < 2; i++) begin rdata[i] = '0; rpc[i] = '0; end
    tbl.push_back(mk(0, 0, 0,            0, 0,     0, 1, 32'h0,   0, NOP, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h0,   0, NOP, 0));
    tbl.push_back(mk(0, 1, 32'h00500093, 0, 0,     0, 0, 32'h4,   1, 32'h00500093, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0,          0, 0,     0, 0, 32'h4,   1, 32'h00500093, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,     1, 1, 32'h4,   0, 32'h00500093, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,     0, 1, 32'h4,   0, 32'h00500093, 0));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h4,   0, 32'h00500093, 0));
    tbl.push_back(mk(0, 1, 32'hAAAA0001, 0, 0,     0, 0, 32'h8,   1, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 0, 0,            0, 0,     1, 1, 32'h8,   0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h8,   0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 0, 0,            1, 32'h103, 0, 0, 32'h100, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 0, 0,            0, 0,     0, 0, 32'h100, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0,     0, 1, 32'h100, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h100, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 1, 32'h11111111, 1, 32'h200, 0, 1, 32'h200, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(1, 0, 0,            1, 32'h300, 0, 0, 32'h300, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 0, 0,            1, 32'h404, 0, 0, 32'h404, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 1, 32'h5555AAAA, 0, 0,     0, 1, 32'h404, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 0, 0,            1, 32'h500, 0, 1, 32'h500, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h500, 0, 32'hAAAA0001, 32'h4));
    tbl.push_back(mk(0, 1, 32'h22222222, 0, 0,     0, 0, 32'h504, 1, 32'h22222222, 32'h500));
    tbl.push_back(mk(0, 1, 32'h33333333, 0, 0,     0, 0, 32'h504, 1, 32'h22222222, 32'h500));
    tbl.push_back(mk(0, 0, 0,            1, 32'h600, 1, 1, 32'h600, 0, 32'h22222222, 32'h500));
    tbl.push_back(mk(1, 0, 0,            0, 0,     0, 0, 32'h600, 0, 32'h22222222, 32'h500));
    tbl.push_back(mk(0, 1, 32'h44444444, 0, 0,     0, 0, 32'h604, 1, 32'h44444444, 32'h600));
    tbl.push_back(mk(0, 0, 0,            0, 0,     1, 1, 32'h604, 0, 32'h44444444, 32'h600));
    repeat (2) @(posedge clk);
    #1;
    chk_out(0, -1, 0, 32'h0, 0, NOP, 0);
    chk_out(1, -1, 0, 32'hFFFF_FFFC, 0, NOP, 0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    foreach (tbl[i]) step(0, i, tbl[i]);
    // Second instance: PC wrap from 0xFFFF_FFFC and asynchronous reset during WAIT.
    @(negedge clk);
    rst_n[1] = 1'b1;
    step(1, 100, mk(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, NOP, 0));
    step(1, 101, mk(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, NOP, 0));
    step(1, 102, mk(0, 1, 32'h12345678, 0, 0, 0, 0, 32'h0, 1, 32'h12345678, 32'hFFFF_FFFC));
    step(1, 103, mk(0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 32'h12345678, 32'hFFFF_FFFC));
    step(1, 104, mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h12345678, 32'hFFFF_FFFC));
    @(negedge clk);
    gnt[1] = 0; rdy[1] = 0;
    rst_n[1] = 1'b0;
    #1;
    chk_out(1, 105, 0, 32'hFFFF_FFFC, 0, NOP, 0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    step(1, 106, mk(0, 1, 32'h77777777, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, NOP, 0));
    step(1, 107, mk(0, 1, 32'h88888888, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, NOP, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
